grpci2_master_arb: RTL and testbench

Two-client command arbiter in front of the GRPCI2 AHB master controller. It accepts unified read/write commands from two requesters (DMA TX and DMA RX engines) and grants one at a time. It issues each granted command on the controller's separate write-command or read-command channel, routes the matching response and read data back to the owner, and exports the current grant so external write-data muxes can follow it. Only one transaction is outstanding at any time, matching the controller's single-transaction sequencing.

---
 rtl/grpci2_master_arb_if.sv | 67 ++++++
 rtl/grpci2_master_arb.sv | 146 ++++++++++++++
 tb/tb_grpci2_master_arb.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/grpci2_master_arb_if.sv
// Bundle of client command/response/read-data channels, controller command/response
// channels and grant outputs for grpci2_master_arb. slave = arbiter side, master = environment.
interface grpci2_master_arb_if;
  logic [3:0]  c0_id,        c1_id;
  logic [7:0]  c0_len,       c1_len;
  logic [63:0] c0_addr,      c1_addr;
  logic        c0_write,     c1_write;
  logic        c0_valid,     c1_valid;
  logic        c0_ready,     c1_ready;
  logic [3:0]  c0_resp_id,   c1_resp_id;
  logic [7:0]  c0_resp_len,  c1_resp_len;
  logic [1:0]  c0_resp_err,  c1_resp_err;
  logic        c0_resp_valid, c1_resp_valid;
  logic        c0_resp_ready, c1_resp_ready;
  logic [31:0] c0_rdata,     c1_rdata;
  logic        c0_rdata_valid, c1_rdata_valid;
  logic        c0_rdata_ready, c1_rdata_ready;

  logic [3:0]  m_wcmd_id,    m_rcmd_id;
  logic [7:0]  m_wcmd_len,   m_rcmd_len;
  logic [63:0] m_wcmd_addr,  m_rcmd_addr;
  logic        m_wcmd_valid, m_rcmd_valid;
  logic        m_wcmd_ready, m_rcmd_ready;
  logic [3:0]  m_wresp_id,   m_rresp_id;
  logic [7:0]  m_wresp_len,  m_rresp_len;
  logic [1:0]  m_wresp_err,  m_rresp_err;
  logic        m_wresp_valid, m_rresp_valid;
  logic        m_wresp_ready, m_rresp_ready;
  logic [31:0] m_rdata;
  logic        m_rdata_valid;
  logic        m_rdata_ready;

  logic        grant_active;
  logic        grant_sel;

  modport slave (
    input  c0_id, c0_len, c0_addr, c0_write, c0_valid, c0_resp_ready, c0_rdata_ready,
    input  c1_id, c1_len, c1_addr, c1_write, c1_valid, c1_resp_ready, c1_rdata_ready,
    output c0_ready, c0_resp_id, c0_resp_len, c0_resp_err, c0_resp_valid, c0_rdata, c0_rdata_valid,
    output c1_ready, c1_resp_id, c1_resp_len, c1_resp_err, c1_resp_valid, c1_rdata, c1_rdata_valid,
    output m_wcmd_id, m_wcmd_len, m_wcmd_addr, m_wcmd_valid,
    output m_rcmd_id, m_rcmd_len, m_rcmd_addr, m_rcmd_valid,
    input  m_wcmd_ready, m_rcmd_ready,
    input  m_wresp_id, m_wresp_len, m_wresp_err, m_wresp_valid,
    input  m_rresp_id, m_rresp_len, m_rresp_err, m_rresp_valid,
    output m_wresp_ready, m_rresp_ready,
    input  m_rdata, m_rdata_valid,
    output m_rdata_ready,
    output grant_active, grant_sel
  );

  modport master (
    output c0_id, c0_len, c0_addr, c0_write, c0_valid, c0_resp_ready, c0_rdata_ready,
    output c1_id, c1_len, c1_addr, c1_write, c1_valid, c1_resp_ready, c1_rdata_ready,
    input  c0_ready, c0_resp_id, c0_resp_len, c0_resp_err, c0_resp_valid, c0_rdata, c0_rdata_valid,
    input  c1_ready, c1_resp_id, c1_resp_len, c1_resp_err, c1_resp_valid, c1_rdata, c1_rdata_valid,
    input  m_wcmd_id, m_wcmd_len, m_wcmd_addr, m_wcmd_valid,
    input  m_rcmd_id, m_rcmd_len, m_rcmd_addr, m_rcmd_valid,
    output m_wcmd_ready, m_rcmd_ready,
    output m_wresp_id, m_wresp_len, m_wresp_err, m_wresp_valid,
    output m_rresp_id, m_rresp_len, m_rresp_err, m_rresp_valid,
    input  m_wresp_ready, m_rresp_ready,
    output m_rdata, m_rdata_valid,
    input  m_rdata_ready,
    input  grant_active, grant_sel
  );
endinterface

// File: rtl/grpci2_master_arb.sv
// Two-client single-outstanding command arbiter for the GRPCI2 AHB master controller.
// Define GRPCI2_ARB_RR_EN for round-robin; otherwise client 0 has fixed priority.
module grpci2_master_arb (
  input  logic               clk,
  input  logic               rst_n,
  grpci2_master_arb_if.slave bus
);
  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_WAIT_RESP = 2'd2;
  localparam logic [1:0] S_RETURN    = 2'd3;

  logic [1:0]  r_state;
  logic [3:0]  r_id;
  logic [7:0]  r_len;
  logic [63:0] r_addr;
  logic        r_write;
  logic [7:0]  r_rlen;
  logic [1:0]  r_err;
  logic        r_grant_active, r_grant_sel;
  logic        r_wcmd_valid, r_rcmd_valid;
  logic        r_wresp_ready, r_rresp_ready;
  logic        r_c0_resp_valid, r_c1_resp_valid;

  logic        w_prio, w_win, w_grant, w_win_write;
  logic        w_cmd_ready, w_resp_valid, w_resp_ack, w_rd_route;
  logic [3:0]  w_resp_id;
  logic [7:0]  w_resp_len;
  logic [1:0]  w_resp_err;

  // Only a simultaneous request consults the pointer; a lone requester always wins.
  assign w_win       = (bus.c0_valid & bus.c1_valid) ? w_prio : bus.c1_valid;
  assign w_grant     = rst_n & (r_state == S_IDLE) & (bus.c0_valid | bus.c1_valid);
  assign w_win_write = w_win ? bus.c1_write : bus.c0_write;
  assign bus.c0_ready = w_grant & ~w_win;
  assign bus.c1_ready = w_grant &  w_win;

  assign w_cmd_ready  = r_write ? bus.m_wcmd_ready  : bus.m_rcmd_ready;
  assign w_resp_valid = r_write ? bus.m_wresp_valid : bus.m_rresp_valid;
  assign w_resp_id    = r_write ? bus.m_wresp_id    : bus.m_rresp_id;
  assign w_resp_len   = r_write ? bus.m_wresp_len   : bus.m_rresp_len;
  assign w_resp_err   = r_write ? bus.m_wresp_err   : bus.m_rresp_err;
  assign w_resp_ack   = r_grant_sel ? bus.c1_resp_ready : bus.c0_resp_ready;

`ifdef GRPCI2_ARB_RR_EN
  logic r_prio;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_prio <= 1'b0;
    else if (r_state == S_RETURN && w_resp_ack)
      r_prio <= ~r_grant_sel;
  end
  assign w_prio = r_prio;
`else
  assign w_prio = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_id            <= '0;
      r_len           <= '0;
      r_addr          <= '0;
      r_write         <= 1'b0;
      r_rlen          <= '0;
      r_err           <= '0;
      r_grant_active  <= 1'b0;
      r_grant_sel     <= 1'b0;
      r_wcmd_valid    <= 1'b0;
      r_rcmd_valid    <= 1'b0;
      r_wresp_ready   <= 1'b0;
      r_rresp_ready   <= 1'b0;
      r_c0_resp_valid <= 1'b0;
      r_c1_resp_valid <= 1'b0;
    end else begin
      r_wresp_ready <= 1'b0;
      r_rresp_ready <= 1'b0;
      case (r_state)
        S_IDLE: if (w_grant) begin
          r_id           <= w_win ? bus.c1_id   : bus.c0_id;
          r_len          <= w_win ? bus.c1_len  : bus.c0_len;
          r_addr         <= w_win ? bus.c1_addr : bus.c0_addr;
          r_write        <= w_win_write;
          r_grant_sel    <= w_win;
          r_grant_active <= 1'b1;
          r_wcmd_valid   <= w_win_write;
          r_rcmd_valid   <= ~w_win_write;
          r_state        <= S_ISSUE;
        end
        S_ISSUE: if (w_cmd_ready) begin
          r_wcmd_valid <= 1'b0;
          r_rcmd_valid <= 1'b0;
          r_state      <= S_WAIT_RESP;
        end
        S_WAIT_RESP: if (w_resp_valid) begin
          r_rlen          <= w_resp_len;
          r_err           <= (w_resp_id != r_id) ? 2'd3 : w_resp_err;
          r_wresp_ready   <= r_write;
          r_rresp_ready   <= ~r_write;
          r_c0_resp_valid <= ~r_grant_sel;
          r_c1_resp_valid <= r_grant_sel;
          r_state         <= S_RETURN;
        end
        default: if (w_resp_ack) begin
          r_c0_resp_valid <= 1'b0;
          r_c1_resp_valid <= 1'b0;
          r_grant_active  <= 1'b0;
          r_state         <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.m_wcmd_id     = r_id;
  assign bus.m_wcmd_len    = r_len;
  assign bus.m_wcmd_addr   = r_addr;
  assign bus.m_wcmd_valid  = r_wcmd_valid;
  assign bus.m_rcmd_id     = r_id;
  assign bus.m_rcmd_len    = r_len;
  assign bus.m_rcmd_addr   = r_addr;
  assign bus.m_rcmd_valid  = r_rcmd_valid;
  assign bus.m_wresp_ready = r_wresp_ready;
  assign bus.m_rresp_ready = r_rresp_ready;

  assign bus.c0_resp_id    = r_id;
  assign bus.c0_resp_len   = r_rlen;
  assign bus.c0_resp_err   = r_err;
  assign bus.c0_resp_valid = r_c0_resp_valid;
  assign bus.c1_resp_id    = r_id;
  assign bus.c1_resp_len   = r_rlen;
  assign bus.c1_resp_err   = r_err;
  assign bus.c1_resp_valid = r_c1_resp_valid;

  assign bus.grant_active  = r_grant_active;
  assign bus.grant_sel     = r_grant_sel;

  // Read data passes straight through to the owner of an in-flight read.
  assign w_rd_route = r_grant_active & ~r_write &
                      ((r_state == S_ISSUE) | (r_state == S_WAIT_RESP));
  assign bus.c0_rdata       = bus.m_rdata;
  assign bus.c1_rdata       = bus.m_rdata;
  assign bus.c0_rdata_valid = w_rd_route & ~r_grant_sel & bus.m_rdata_valid;
  assign bus.c1_rdata_valid = w_rd_route &  r_grant_sel & bus.m_rdata_valid;
  assign bus.m_rdata_ready  = w_rd_route &
                              (r_grant_sel ? bus.c1_rdata_ready : bus.c0_rdata_ready);
endmodule

// File: tb/tb_grpci2_master_arb.sv
// Scoreboard bench for grpci2_master_arb: queued expected grants, commands and responses
// are compared as the arbiter produces them; a behavioural controller answers commands.
module tb_grpci2_master_arb;
`ifdef GRPCI2_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct { int c; logic [3:0] id; logic [7:0] len; logic [63:0] addr; logic wr; } cmd_t;
  typedef struct { logic [3:0] id; logic [7:0] len; logic [1:0] err; } rsp_t;

  logic clk;
  logic rst_n;
  grpci2_master_arb_if bus ();

  grpci2_master_arb u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int   n_chk = 0;
  int   n_fail = 0;
  int   q_gnt[$];
  cmd_t q_cmd[$];
  rsp_t q_rsp0[$];
  rsp_t q_rsp1[$];

  int   cfg_delay = 0;
  bit   cfg_no_resp = 0;
  bit   cfg_id_ovr = 0;
  logic [3:0] cfg_rid = '0;
  logic [1:0] cfg_err = '0;

  int   cur_owner = 0;
  int   sel_bad = 0;
  int   beats0 = 0, beats1 = 0;
  int   wcmd_seen = 0, rcmd_seen = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic expect_txn(input int c, input logic [3:0] id, input logic [7:0] len,
                            input logic [63:0] addr, input logic wr, input logic [1:0] err);
    cmd_t cm;
    rsp_t rs;
    cm = '{c, id, len, addr, wr};
    rs = '{id, len, err};
    q_gnt.push_back(c);
    q_cmd.push_back(cm);
    if (c == 0) q_rsp0.push_back(rs);
    else        q_rsp1.push_back(rs);
  endtask

  task automatic set_client(input int c, input logic v, input logic [3:0] id,
                            input logic [7:0] len, input logic [63:0] addr, input logic wr);
    if (c == 0) begin
      bus.c0_valid = v; bus.c0_id = id; bus.c0_len = len; bus.c0_addr = addr; bus.c0_write = wr;
    end else begin
      bus.c1_valid = v; bus.c1_id = id; bus.c1_len = len; bus.c1_addr = addr; bus.c1_write = wr;
    end
  endtask

  task automatic client_req(input int c, input logic [3:0] id, input logic [7:0] len,
                            input logic [63:0] addr, input logic wr);
    int  t;
    logic seen;
    @(posedge clk); #1;
    set_client(c, 1'b1, id, len, addr, wr);
    t = 0;
    seen = 1'b0;
    while (!seen && t < 200) begin
      @(negedge clk);
      t++;
      seen = (c == 0) ? bus.c0_ready : bus.c1_ready;
    end
    if (!seen) chk("req_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    set_client(c, 1'b0, id, len, addr, wr);
  endtask

  task automatic contend(input int n);
    int g, t;
    @(posedge clk); #1;
    set_client(0, 1'b1, 4'h1, 8'd0, 64'h3000, 1'b1);
    set_client(1, 1'b1, 4'h2, 8'd0, 64'h4000, 1'b1);
    g = 0;
    t = 0;
    while (g < n && t < 400) begin
      @(negedge clk);
      t++;
      if (bus.c0_ready | bus.c1_ready) g++;
    end
    if (g < n) chk("contend_timeout", 64'(g), 64'(n));
    @(posedge clk); #1;
    bus.c0_valid = 1'b0;
    bus.c1_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((q_rsp0.size() != 0 || q_rsp1.size() != 0 || bus.grant_active) && t < 500);
    if (t >= 500) chk(tag, 64'd0, 64'd1);
  endtask

  task automatic ctrl_model();
    logic       wr;
    logic [3:0] id;
    logic [7:0] len;
    int         t;
    forever begin
      @(negedge clk);
      if (!rst_n || !(bus.m_wcmd_valid || bus.m_rcmd_valid)) continue;
      wr  = bus.m_wcmd_valid;
      id  = wr ? bus.m_wcmd_id  : bus.m_rcmd_id;
      len = wr ? bus.m_wcmd_len : bus.m_rcmd_len;
      repeat (cfg_delay) @(posedge clk);
      @(posedge clk); #1;
      if (wr) bus.m_wcmd_ready = 1'b1;
      else    bus.m_rcmd_ready = 1'b1;
      @(posedge clk); #1;
      bus.m_wcmd_ready = 1'b0;
      bus.m_rcmd_ready = 1'b0;
      if (cfg_no_resp) continue;
      if (!wr) begin
        for (int b = 0; b <= int'(len); b++) begin
          bus.m_rdata       = 32'(32'hA000_0000 + b);
          bus.m_rdata_valid = 1'b1;
          t = 0;
          do begin
            @(negedge clk);
            t++;
          end while (!bus.m_rdata_ready && t < 100);
          if (!bus.m_rdata_ready) chk("rdata_accept_timeout", 64'd0, 64'd1);
          @(posedge clk); #1;
        end
        bus.m_rdata_valid = 1'b0;
      end
      if (wr) begin
        bus.m_wresp_id = cfg_id_ovr ? cfg_rid : id;
        bus.m_wresp_len = len; bus.m_wresp_err = cfg_err; bus.m_wresp_valid = 1'b1;
      end else begin
        bus.m_rresp_id = cfg_id_ovr ? cfg_rid : id;
        bus.m_rresp_len = len; bus.m_rresp_err = cfg_err; bus.m_rresp_valid = 1'b1;
      end
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!(wr ? bus.m_wresp_ready : bus.m_rresp_ready) && t < 100);
      if (t >= 100) chk("resp_accept_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      bus.m_wresp_valid = 1'b0;
      bus.m_rresp_valid = 1'b0;
    end
  endtask

  // Monitors compare DUT activity against the queued expectations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.c0_ready | bus.c1_ready) begin
        if (q_gnt.size() == 0) chk("grant_unexpected", 64'd1, 64'd0);
        else begin
          cur_owner = q_gnt.pop_front();
          chk("grant_client", 64'(bus.c1_ready), 64'(cur_owner));
        end
      end
      if (bus.grant_active && bus.grant_sel !== 1'(cur_owner)) sel_bad++;
      if (bus.m_wcmd_valid) wcmd_seen++;
      if (bus.m_rcmd_valid) rcmd_seen++;
      if ((bus.m_wcmd_valid && bus.m_wcmd_ready) || (bus.m_rcmd_valid && bus.m_rcmd_ready)) begin
        if (q_cmd.size() == 0) chk("cmd_unexpected", 64'd1, 64'd0);
        else begin
          cmd_t e;
          e = q_cmd.pop_front();
          chk("cmd_write", 64'(bus.m_wcmd_valid), 64'(e.wr));
          chk("cmd_id",   64'(e.wr ? bus.m_wcmd_id   : bus.m_rcmd_id),   64'(e.id));
          chk("cmd_len",  64'(e.wr ? bus.m_wcmd_len  : bus.m_rcmd_len),  64'(e.len));
          chk("cmd_addr", e.wr ? bus.m_wcmd_addr : bus.m_rcmd_addr, e.addr);
          chk("cmd_grant_sel", 64'(bus.grant_sel), 64'(e.c));
        end
      end
      if (bus.c0_resp_valid && bus.c0_resp_ready) begin
        if (q_rsp0.size() == 0) chk("c0_resp_unexpected", 64'd1, 64'd0);
        else begin
          rsp_t r;
          r = q_rsp0.pop_front();
          chk("c0_resp_id",  64'(bus.c0_resp_id),  64'(r.id));
          chk("c0_resp_len", 64'(bus.c0_resp_len), 64'(r.len));
          chk("c0_resp_err", 64'(bus.c0_resp_err), 64'(r.err));
        end
      end
      if (bus.c1_resp_valid && bus.c1_resp_ready) begin
        if (q_rsp1.size() == 0) chk("c1_resp_unexpected", 64'd1, 64'd0);
        else begin
          rsp_t r;
          r = q_rsp1.pop_front();
          chk("c1_resp_id",  64'(bus.c1_resp_id),  64'(r.id));
          chk("c1_resp_len", 64'(bus.c1_resp_len), 64'(r.len));
          chk("c1_resp_err", 64'(bus.c1_resp_err), 64'(r.err));
        end
      end
      if (bus.c0_rdata_valid && bus.c0_rdata_ready) beats0++;
      if (bus.c1_rdata_valid && bus.c1_rdata_ready) begin
        chk("c1_rdata", 64'(bus.c1_rdata), 64'(32'(32'hA000_0000 + beats1)));
        beats1++;
      end
    end
  end

  function automatic logic [11:0] ctl_vec();
    return {bus.c0_ready, bus.c1_ready, bus.c0_resp_valid, bus.c1_resp_valid,
            bus.c0_rdata_valid, bus.c1_rdata_valid, bus.m_wcmd_valid, bus.m_rcmd_valid,
            bus.m_wresp_ready, bus.m_rresp_ready, bus.m_rdata_ready, bus.grant_active};
  endfunction

  initial begin
    int t, hold_bad, early;
    rst_n = 1'b0;
    set_client(0, 1'b1, '0, '0, '0, 1'b0);
    set_client(1, 1'b0, '0, '0, '0, 1'b0);
    bus.c0_resp_ready = 1'b1; bus.c1_resp_ready = 1'b1;
    bus.c0_rdata_ready = 1'b1; bus.c1_rdata_ready = 1'b1;
    bus.m_wcmd_ready = 1'b0; bus.m_rcmd_ready = 1'b0;
    bus.m_wresp_id = '0; bus.m_wresp_len = '0; bus.m_wresp_err = '0; bus.m_wresp_valid = 1'b0;
    bus.m_rresp_id = '0; bus.m_rresp_len = '0; bus.m_rresp_err = '0; bus.m_rresp_valid = 1'b0;
    bus.m_rdata = '0; bus.m_rdata_valid = 1'b0;
    fork ctrl_model(); join_none

    repeat (3) @(negedge clk);
    chk("reset_ctl_zero", 64'(ctl_vec()), 64'd0);
    chk("reset_grant_sel", 64'(bus.grant_sel), 64'd0);
    chk("reset_resp_id", 64'(bus.c0_resp_id), 64'd0);
    chk("reset_cmd_addr", bus.m_wcmd_addr, 64'd0);
    bus.c0_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single write from client 0, controller ready delayed.
    cfg_delay = 2;
    sel_bad = 0;
    expect_txn(0, 4'h3, 8'd7, 64'h1000, 1'b1, 2'd0);
    client_req(0, 4'h3, 8'd7, 64'h1000, 1'b1);
    wait_done("t1_timeout");
    chk("t1_grant_sel_stable", 64'(sel_bad), 64'd0);
    cfg_delay = 0;

    // Single read from client 1, four beats.
    beats0 = 0; beats1 = 0; wcmd_seen = 0; rcmd_seen = 0;
    expect_txn(1, 4'h9, 8'd3, 64'h2000, 1'b0, 2'd0);
    client_req(1, 4'h9, 8'd3, 64'h2000, 1'b0);
    wait_done("t2_timeout");
    chk("t2_c1_beats", 64'(beats1), 64'd4);
    chk("t2_c0_beats", 64'(beats0), 64'd0);
    chk("t2_wcmd_never", 64'(wcmd_seen), 64'd0);
    chk("t2_rcmd_seen", 64'(rcmd_seen != 0), 64'd1);

    // Contention: both clients valid every cycle for four grants.
    for (int k = 0; k < 4; k++) begin
      if ((RR ? (k % 2) : 0) == 0) expect_txn(0, 4'h1, 8'd0, 64'h3000, 1'b1, 2'd0);
      else                         expect_txn(1, 4'h2, 8'd0, 64'h4000, 1'b1, 2'd0);
    end
    contend(4);
    wait_done("t3_timeout");
    chk("t3_grants_consumed", 64'(q_gnt.size()), 64'd0);

    // Response id mismatch forces DECERR.
    cfg_id_ovr = 1'b1; cfg_rid = 4'h6; cfg_err = 2'd0;
    expect_txn(0, 4'h5, 8'd2, 64'h5000, 1'b1, 2'd3);
    client_req(0, 4'h5, 8'd2, 64'h5000, 1'b1);
    wait_done("t4_timeout");
    cfg_id_ovr = 1'b0;

    // Reset while waiting for the controller response.
    cfg_no_resp = 1'b1;
    q_gnt.push_back(0);
    q_cmd.push_back('{0, 4'h4, 8'd0, 64'h6000, 1'b1});
    client_req(0, 4'h4, 8'd0, 64'h6000, 1'b1);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(bus.m_wcmd_valid && bus.m_wcmd_ready) && t < 100);
    if (t >= 100) chk("t6_cmd_timeout", 64'd0, 64'd1);
    @(negedge clk);
    chk("t6_in_wait_resp", 64'(bus.grant_active), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_reset_ctl_zero", 64'(ctl_vec()), 64'd0);
    chk("t6_reset_grant_sel", 64'(bus.grant_sel), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cfg_no_resp = 1'b0;
    expect_txn(0, 4'h1, 8'd0, 64'h3000, 1'b1, 2'd0);
    if (RR) expect_txn(1, 4'h2, 8'd0, 64'h4000, 1'b1, 2'd0);
    else    expect_txn(0, 4'h1, 8'd0, 64'h3000, 1'b1, 2'd0);
    contend(2);
    wait_done("t6_contend_timeout");
    expect_txn(1, 4'hC, 8'd1, 64'h9000, 1'b1, 2'd0);
    client_req(1, 4'hC, 8'd1, 64'h9000, 1'b1);
    wait_done("t6_c1_timeout");

    // Response backpressure on client 0 with a competing request from client 1.
    bus.c0_resp_ready = 1'b0;
    expect_txn(0, 4'h7, 8'd1, 64'h7000, 1'b1, 2'd0);
    client_req(0, 4'h7, 8'd1, 64'h7000, 1'b1);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.c0_resp_valid && t < 100);
    if (t >= 100) chk("t5_resp_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    set_client(1, 1'b1, 4'hA, 8'd0, 64'h8000, 1'b1);
    hold_bad = 0;
    early = 0;
    repeat (10) begin
      @(negedge clk);
      if (!(bus.c0_resp_valid && bus.c0_resp_id == 4'h7 && bus.c0_resp_len == 8'd1 &&
            bus.c0_resp_err == 2'd0 && bus.grant_active && !bus.grant_sel)) hold_bad++;
      if (bus.c1_ready) early++;
    end
    chk("t5_resp_stable", 64'(hold_bad), 64'd0);
    chk("t5_no_new_grant", 64'(early), 64'd0);
    expect_txn(1, 4'hA, 8'd0, 64'h8000, 1'b1, 2'd0);
    @(posedge clk); #1;
    bus.c0_resp_ready = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.c1_ready && t < 100);
    if (t >= 100) chk("t5_c1_grant_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    set_client(1, 1'b0, 4'hA, 8'd0, 64'h8000, 1'b1);
    wait_done("t5_timeout");

    chk("end_q_gnt_empty", 64'(q_gnt.size()), 64'd0);
    chk("end_q_cmd_empty", 64'(q_cmd.size()), 64'd0);
    chk("end_q_rsp_empty", 64'(q_rsp0.size() + q_rsp1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
